fb_rect_writer: RTL and testbench

Command-driven pixel writer that fills axis-aligned rectangles, or the whole screen, into the 2-bit overlay frame buffer through its write port. It accepts one draw command at a time over a valid/ready handshake. It clips the rectangle to the visible area and emits one pixel write per cycle on WRITE_CLK, using the same linear addressing the read side uses: addr = y*VGA_WIDTH + x. It sits between the game logic (ball, paddles, score) and the frame buffer write port.

---
 rtl/fb_pkg.sv | 27 ++
 rtl/fb_rect_writer.sv | 220 ++++++++++++++++++++++
 tb/tb_fb_rect_writer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the overlay frame-buffer writer.
//   FB_VGA_WIDTH / FB_VGA_HEIGHT : default visible resolution
//   FB_*_W                       : field widths for address, coordinates and colour
//   fb_state_t                   : rectangle writer FSM state encoding
package fb_pkg;

  localparam int FB_VGA_WIDTH  = 640;
  localparam int FB_VGA_HEIGHT = 480;

  localparam int FB_ADDR_W  = 19;
  localparam int FB_X_W     = 10;
  localparam int FB_Y_W     = 9;
  localparam int FB_COLOR_W = 2;
  localparam int FB_DATA_W  = 24;

  // One extra bit so x+w and y+h cannot wrap.
  localparam int FB_XS_W = FB_X_W + 1;
  localparam int FB_YS_W = FB_Y_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_DRAW   = 2'd2,
    ST_FINISH = 2'd3
  } fb_state_t;

endpackage

// File: rtl/fb_rect_writer.sv
// Command-driven rectangle / full-screen filler for the 2-bit overlay frame
// buffer. One command at a time; the rectangle is clipped to the visible area
// and written one pixel per clock, row-major, at addr = y*VGA_WIDTH + x.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | CMD_READY=1, waiting for CMD_VALID; captures the command
// SETUP  | clip to screen, decide empty/non-empty, preload first write
// DRAW   | one WRITE_EN per cycle, stepping column then row
// FINISH | one-cycle DONE pulse, then back to IDLE
//
// Ports:
//   WRITE_CLK, RESET                  clock, synchronous active-high reset
//   CMD_VALID/CMD_READY               command handshake
//   CMD_CLEAR, CMD_X/Y/W/H, CMD_COLOR command fields
//   WRITE_EN/WRITE_ADDR/WRITE_DATA    frame-buffer write port (registered)
//   BUSY, DONE                        status (registered)
module fb_rect_writer
  import fb_pkg::*;
#(
  parameter int VGA_WIDTH  = FB_VGA_WIDTH,
  parameter int VGA_HEIGHT = FB_VGA_HEIGHT
) (
  input  logic                  WRITE_CLK,
  input  logic                  RESET,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic                  CMD_CLEAR,
  input  logic [FB_X_W-1:0]     CMD_X,
  input  logic [FB_Y_W-1:0]     CMD_Y,
  input  logic [FB_X_W-1:0]     CMD_W,
  input  logic [FB_Y_W-1:0]     CMD_H,
  input  logic [FB_COLOR_W-1:0] CMD_COLOR,
  output logic                  WRITE_EN,
  output logic [FB_ADDR_W-1:0]  WRITE_ADDR,
  output logic [FB_DATA_W-1:0]  WRITE_DATA,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam logic [FB_XS_W-1:0]   X_LIM    = FB_XS_W'(VGA_WIDTH);
  localparam logic [FB_YS_W-1:0]   Y_LIM    = FB_YS_W'(VGA_HEIGHT);
  localparam logic [FB_ADDR_W-1:0] ROW_STEP = FB_ADDR_W'(VGA_WIDTH);

  fb_state_t state, state_n;

  logic                  cap_clear, cap_clear_n;
  logic [FB_X_W-1:0]     cap_x, cap_x_n, cap_w, cap_w_n;
  logic [FB_Y_W-1:0]     cap_y, cap_y_n, cap_h, cap_h_n;
  logic [FB_COLOR_W-1:0] cap_color, cap_color_n;

  logic [FB_X_W-1:0]     x0, x0_n, col, col_n;
  logic [FB_XS_W-1:0]    x1, x1_n;
  logic [FB_YS_W-1:0]    y1, y1_n;
  logic [FB_Y_W-1:0]     row, row_n;
  logic [FB_ADDR_W-1:0]  row_base, row_base_n;

  logic                  ready_r, ready_n, busy_r, busy_n, done_r, done_n;
  logic                  we_r, we_n;
  logic [FB_ADDR_W-1:0]  addr_r, addr_n;
  logic [FB_COLOR_W-1:0] color_r, color_n;

  // Clip terms, only meaningful in SETUP.
  logic [FB_XS_W-1:0]   sum_x, end_x;
  logic [FB_YS_W-1:0]   sum_y, end_y;
  logic [FB_X_W-1:0]    start_x;
  logic [FB_Y_W-1:0]    start_y;
  logic [FB_ADDR_W-1:0] start_base;
  logic                 empty;
  logic                 col_last, row_last;

  always_comb begin
    sum_x   = {1'b0, cap_x} + {1'b0, cap_w};
    sum_y   = {1'b0, cap_y} + {1'b0, cap_h};
    start_x = cap_clear ? '0 : cap_x;
    start_y = cap_clear ? '0 : cap_y;
    end_x   = (cap_clear || sum_x > X_LIM) ? X_LIM : sum_x;
    end_y   = (cap_clear || sum_y > Y_LIM) ? Y_LIM : sum_y;
    empty   = !cap_clear && (cap_w == '0 || cap_h == '0 ||
                             {1'b0, cap_x} >= X_LIM || {1'b0, cap_y} >= Y_LIM);
    // Constant multiply, used once per command; DRAW only adds ROW_STEP.
    start_base = {{(FB_ADDR_W-FB_Y_W){1'b0}}, start_y} * ROW_STEP;
    col_last   = ({1'b0, col} == x1 - 1'b1);
    row_last   = ({1'b0, row} == y1 - 1'b1);
  end

  always_comb begin
    state_n     = state;
    cap_clear_n = cap_clear;
    cap_x_n     = cap_x;
    cap_y_n     = cap_y;
    cap_w_n     = cap_w;
    cap_h_n     = cap_h;
    cap_color_n = cap_color;
    x0_n        = x0;
    x1_n        = x1;
    y1_n        = y1;
    col_n       = col;
    row_n       = row;
    row_base_n  = row_base;
    ready_n     = ready_r;
    busy_n      = busy_r;
    done_n      = 1'b0;
    we_n        = 1'b0;
    addr_n      = addr_r;
    color_n     = color_r;

    case (state)
      ST_IDLE: begin
        if (CMD_VALID) begin
          cap_clear_n = CMD_CLEAR;
          cap_x_n     = CMD_X;
          cap_y_n     = CMD_Y;
          cap_w_n     = CMD_W;
          cap_h_n     = CMD_H;
          cap_color_n = CMD_COLOR;
          ready_n     = 1'b0;
          busy_n      = 1'b1;
          state_n     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (empty) begin
          done_n  = 1'b1;
          state_n = ST_FINISH;
        end else begin
          x0_n       = start_x;
          x1_n       = end_x;
          y1_n       = end_y;
          col_n      = start_x;
          row_n      = start_y;
          row_base_n = start_base;
          // First pixel is presented in the very first DRAW cycle.
          we_n       = 1'b1;
          addr_n     = start_base + {{(FB_ADDR_W-FB_X_W){1'b0}}, start_x};
          color_n    = cap_color;
          state_n    = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (col_last && row_last) begin
          done_n  = 1'b1;
          state_n = ST_FINISH;
        end else if (col_last) begin
          we_n       = 1'b1;
          col_n      = x0;
          row_n      = row + 1'b1;
          row_base_n = row_base + ROW_STEP;
          addr_n     = row_base + ROW_STEP + {{(FB_ADDR_W-FB_X_W){1'b0}}, x0};
        end else begin
          we_n   = 1'b1;
          col_n  = col + 1'b1;
          addr_n = addr_r + 1'b1;
        end
      end
      ST_FINISH: begin
        ready_n = 1'b1;
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
      default: begin
        ready_n = 1'b1;
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge WRITE_CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      cap_clear <= 1'b0;
      cap_x     <= '0;
      cap_y     <= '0;
      cap_w     <= '0;
      cap_h     <= '0;
      cap_color <= '0;
      x0        <= '0;
      x1        <= '0;
      y1        <= '0;
      col       <= '0;
      row       <= '0;
      row_base  <= '0;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      we_r      <= 1'b0;
      addr_r    <= '0;
      color_r   <= '0;
    end else begin
      state     <= state_n;
      cap_clear <= cap_clear_n;
      cap_x     <= cap_x_n;
      cap_y     <= cap_y_n;
      cap_w     <= cap_w_n;
      cap_h     <= cap_h_n;
      cap_color <= cap_color_n;
      x0        <= x0_n;
      x1        <= x1_n;
      y1        <= y1_n;
      col       <= col_n;
      row       <= row_n;
      row_base  <= row_base_n;
      ready_r   <= ready_n;
      busy_r    <= busy_n;
      done_r    <= done_n;
      we_r      <= we_n;
      addr_r    <= addr_n;
      color_r   <= color_n;
    end
  end

  assign CMD_READY  = ready_r;
  assign BUSY       = busy_r;
  assign DONE       = done_r;
  assign WRITE_EN   = we_r;
  assign WRITE_ADDR = addr_r;
  assign WRITE_DATA = {{(FB_DATA_W-FB_COLOR_W){1'b0}}, color_r};

endmodule

// File: tb/tb_fb_rect_writer.sv
// Directed bench for fb_rect_writer. A full-size instance covers addressing,
// clipping, empty commands, back-to-back commands and reset; a 16x12 instance
// covers the full-screen clear in a short run.
module tb_fb_rect_writer;
  import fb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Full-size instance
  logic        rst = 1'b1, v = 1'b0, clr = 1'b0;
  logic [9:0]  x = '0, w = '0;
  logic [8:0]  y = '0, h = '0;
  logic [1:0]  col = '0;
  logic        rdy, we, busy, done;
  logic [18:0] addr;
  logic [23:0] data;

  // Small instance
  logic        s_rst = 1'b1, s_v = 1'b0, s_clr = 1'b0;
  logic [9:0]  s_x = '0, s_w = '0;
  logic [8:0]  s_y = '0, s_h = '0;
  logic [1:0]  s_col = '0;
  logic        s_rdy, s_we, s_busy, s_done;
  logic [18:0] s_addr;
  logic [23:0] s_data;

  fb_rect_writer dut (
    .WRITE_CLK(clk), .RESET(rst), .CMD_VALID(v), .CMD_READY(rdy),
    .CMD_CLEAR(clr), .CMD_X(x), .CMD_Y(y), .CMD_W(w), .CMD_H(h),
    .CMD_COLOR(col), .WRITE_EN(we), .WRITE_ADDR(addr), .WRITE_DATA(data),
    .BUSY(busy), .DONE(done)
  );

  fb_rect_writer #(.VGA_WIDTH(16), .VGA_HEIGHT(12)) dut_s (
    .WRITE_CLK(clk), .RESET(s_rst), .CMD_VALID(s_v), .CMD_READY(s_rdy),
    .CMD_CLEAR(s_clr), .CMD_X(s_x), .CMD_Y(s_y), .CMD_W(s_w), .CMD_H(s_h),
    .CMD_COLOR(s_col), .WRITE_EN(s_we), .WRITE_ADDR(s_addr), .WRITE_DATA(s_data),
    .BUSY(s_busy), .DONE(s_done)
  );

  bit          sel = 1'b0;
  logic        m_rdy, m_we, m_busy, m_done;
  logic [18:0] m_addr;
  logic [23:0] m_data;
  always_comb begin
    m_rdy  = sel ? s_rdy  : rdy;
    m_we   = sel ? s_we   : we;
    m_busy = sel ? s_busy : busy;
    m_done = sel ? s_done : done;
    m_addr = sel ? s_addr : addr;
    m_data = sel ? s_data : data;
  end

  // Write log: address, data and cycle stamp (stamp = edge that ends the cycle).
  int q_addr[$];
  int q_data[$];
  int q_t[$];
  int n_done = 0;
  always @(negedge clk) begin
    if (m_we) begin
      q_addr.push_back(int'(m_addr));
      q_data.push_back(int'(m_data));
      q_t.push_back(cyc + 1);
    end
    if (m_done) n_done++;
  end

  int n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit vv, input bit c, input logic [9:0] xx, input logic [8:0] yy,
                       input logic [9:0] ww, input logic [8:0] hh, input logic [1:0] cc);
    if (sel) begin
      s_v = vv; s_clr = c; s_x = xx; s_y = yy; s_w = ww; s_h = hh; s_col = cc;
    end else begin
      v = vv; clr = c; x = xx; y = yy; w = ww; h = hh; col = cc;
    end
  endtask

  task automatic send(input bit c, input logic [9:0] xx, input logic [8:0] yy,
                      input logic [9:0] ww, input logic [8:0] hh, input logic [1:0] cc,
                      output int hs);
    @(negedge clk);
    q_addr.delete(); q_data.delete(); q_t.delete();
    drive(1'b1, c, xx, yy, ww, hh, cc);
    @(negedge clk);
    hs = cyc;
    drive(1'b0, 1'b0, '0, '0, '0, '0, '0);
  endtask

  task automatic wait_done(input string tag, input int max, output int t_done, output int rdy_seen);
    bit got = 1'b0;
    rdy_seen = 0;
    t_done = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (m_rdy) rdy_seen++;
      if (m_done) begin
        t_done = cyc + 1;
        got = 1'b1;
        break;
      end
    end
    if (!got) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_cmd(input string tag, input bit c, input logic [9:0] xx, input logic [8:0] yy,
                         input logic [9:0] ww, input logic [8:0] hh, input logic [1:0] cc,
                         input int exp_a[$], input int max);
    int hs, td, rs;
    send(c, xx, yy, ww, hh, cc, hs);
    check({tag, "_setup_rdy"}, 32'(m_rdy), 32'd0);
    check({tag, "_setup_busy"}, 32'(m_busy), 32'd1);
    wait_done(tag, max, td, rs);
    check({tag, "_count"}, 32'(q_addr.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size(); i++) begin
      if (i < q_addr.size()) begin
        check({tag, "_addr"}, 32'(q_addr[i]), 32'(exp_a[i]));
        check({tag, "_data"}, 32'(q_data[i]), 32'(cc));
        check({tag, "_stamp"}, 32'(q_t[i] - hs), 32'(2 + i));
      end
    end
    check({tag, "_done_off"}, 32'(td - hs), 32'(2 + exp_a.size()));
    check({tag, "_rdy_low"}, 32'(rs), 32'd0);
    @(negedge clk);
    check({tag, "_rdy_back"}, 32'(m_rdy), 32'd1);
    check({tag, "_busy_low"}, 32'(m_busy), 32'd0);
  endtask

  initial begin
    int eq[$];
    int hs_a, hs_b, td, rs, cnt, nd0;
    bit got;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    s_rst = 1'b0;
    check("rst_rdy", 32'(rdy), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_data", 32'(data), 32'd0);

    eq = '{1290, 1291, 1292, 1930, 1931, 1932};
    run_cmd("rect", 1'b0, 10'd10, 9'd2, 10'd3, 9'd2, 2'd1, eq, 50);

    eq = '{307198, 307199};
    run_cmd("clip", 1'b0, 10'd638, 9'd479, 10'd5, 9'd4, 2'd3, eq, 50);

    eq = '{};
    run_cmd("w0", 1'b0, 10'd5, 9'd5, 10'd0, 9'd3, 2'd2, eq, 20);
    run_cmd("x700", 1'b0, 10'd700, 9'd5, 10'd4, 9'd3, 2'd2, eq, 20);
    run_cmd("h0", 1'b0, 10'd5, 9'd5, 10'd4, 9'd0, 2'd1, eq, 20);

    // Row wrap with a 1-wide column of 3 rows.
    eq = '{20, 660, 1300};
    run_cmd("col1", 1'b0, 10'd20, 9'd0, 10'd1, 9'd3, 2'd2, eq, 50);

    // Two commands with CMD_VALID held high throughout.
    @(negedge clk);
    q_addr.delete(); q_data.delete(); q_t.delete();
    drive(1'b1, 1'b0, 10'd0, 9'd0, 10'd2, 9'd1, 2'd2);
    @(negedge clk);
    hs_a = cyc;
    drive(1'b1, 1'b0, 10'd5, 9'd1, 10'd1, 9'd2, 2'd3);
    got = 1'b0;
    hs_b = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_rdy) begin
        hs_b = cyc + 1;
        got = 1'b1;
        break;
      end
    end
    if (!got) check("b2b_timeout", 32'd0, 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, '0, '0, '0);
    wait_done("b2b", 20, td, rs);
    check("b2b_accept", 32'(hs_b - hs_a), 32'd5);
    check("b2b_count", 32'(q_addr.size()), 32'd4);
    eq = '{0, 1, 645, 1285};
    for (int i = 0; i < 4; i++) begin
      if (i < q_addr.size()) begin
        check("b2b_addr", 32'(q_addr[i]), 32'(eq[i]));
        check("b2b_data", 32'(q_data[i]), (i < 2) ? 32'd2 : 32'd3);
        check("b2b_stamp", 32'(q_t[i]), (i < 2) ? 32'(hs_a + 2 + i) : 32'(hs_b + i));
      end
    end
    check("b2b_done", 32'(td - hs_b), 32'd4);
    @(negedge clk);

    // Reset during the 4th write of a 10x10 rectangle.
    nd0 = n_done;
    send(1'b0, 10'd0, 9'd0, 10'd10, 9'd10, 2'd1, hs_a);
    cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_we) cnt++;
      if (cnt == 4) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("rst_mid_timeout", 32'd0, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_we", 32'(we), 32'd0);
    check("rst_mid_addr", 32'(addr), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_rdy", 32'(rdy), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_writes", 32'(q_addr.size()), 32'd4);
    check("rst_mid_nodone", 32'(n_done - nd0), 32'd0);
    eq = '{3};
    run_cmd("after_rst", 1'b0, 10'd3, 9'd0, 10'd1, 9'd1, 2'd3, eq, 20);

    // Small screen: full clear and corner clip.
    sel = 1'b1;
    eq = '{};
    for (int i = 0; i < 16 * 12; i++) eq.push_back(i);
    run_cmd("clear", 1'b1, 10'd7, 9'd3, 10'd1, 9'd1, 2'd2, eq, 300);
    eq = '{190, 191};
    run_cmd("s_clip", 1'b0, 10'd14, 9'd11, 10'd5, 9'd4, 2'd1, eq, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
